// File: rtl/mmio_bus_arbiter.sv
// Two-master round-robin arbiter for the MMIO bus: one transaction at a time,
// sequenced IDLE -> BUS -> ACK, with registered read data returned on ack.
module mmio_bus_arbiter #(
   parameter int ADDR_W = 21,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wr_data,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rd_data,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wr_data,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rd_data,
   output logic              b_mmio_cs,
   output logic              b_wr,
   output logic              b_rd,
   output logic [ADDR_W-1:0] b_addr,
   output logic [DATA_W-1:0] b_wr_data,
   input  logic [DATA_W-1:0] b_rd_data,
   output logic              gnt,
   output logic              busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUS  = 2'd1;
   localparam logic [1:0] ACK  = 2'd2;

   logic [1:0]        state;
   logic              last;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              sel;

   // On a tie the master that was not served last wins.
   always_comb sel = (m0_req & m1_req) ? ~last : m1_req;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         last    <= 1'b1;
         gnt     <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (m0_req | m1_req) begin
                  gnt     <= sel;
                  we_q    <= sel ? m1_we      : m0_we;
                  addr_q  <= sel ? m1_addr    : m0_addr;
                  wdata_q <= sel ? m1_wr_data : m0_wr_data;
                  state   <= BUS;
               end
            end
            BUS: begin
               if (!we_q) rdata_q <= b_rd_data;
               state <= ACK;
            end
            ACK: begin
               last  <= gnt;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Bus is driven only in BUS so no stale address ever reaches the slave.
   assign b_mmio_cs  = (state == BUS);
   assign b_wr       = b_mmio_cs & we_q;
   assign b_rd       = b_mmio_cs & ~we_q;
   assign b_addr     = b_mmio_cs ? addr_q  : '0;
   assign b_wr_data  = b_mmio_cs ? wdata_q : '0;

   assign m0_ack     = (state == ACK) & ~gnt;
   assign m1_ack     = (state == ACK) &  gnt;
   assign m0_rd_data = m0_ack ? rdata_q : '0;
   assign m1_rd_data = m1_ack ? rdata_q : '0;

   assign busy       = (state == BUS) | (state == ACK);

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Scoreboard bench: a transaction-level model predicts bus and ack events into
// queues; a negedge monitor pops and compares them against the DUT every cycle.
module tb_mmio_bus_arbiter;
   localparam int ADDR_W = 21;
   localparam int DATA_W = 32;

   logic clk = 0;
   logic reset;
   logic [1:0] req, we;
   logic [ADDR_W-1:0] addr [2];
   logic [DATA_W-1:0] wd [2];
   logic m0_ack, m1_ack, b_mmio_cs, b_wr, b_rd, gnt, busy;
   logic [DATA_W-1:0] m0_rd_data, m1_rd_data, b_wr_data, b_rd_data;
   logic [ADDR_W-1:0] b_addr;
   wire  [1:0] ack = {m1_ack, m0_ack};

   int nvec = 0, nfail = 0, cyc = 0;

   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] slave_f(logic [ADDR_W-1:0] a);
      if (a == 21'h00010) return 32'hDEADBEEF;
      return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction
   assign b_rd_data = slave_f(b_addr);

   mmio_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset(reset),
      .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wr_data(wd[0]),
      .m0_ack(m0_ack), .m0_rd_data(m0_rd_data),
      .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wr_data(wd[1]),
      .m1_ack(m1_ack), .m1_rd_data(m1_rd_data),
      .b_mmio_cs(b_mmio_cs), .b_wr(b_wr), .b_rd(b_rd), .b_addr(b_addr),
      .b_wr_data(b_wr_data), .b_rd_data(b_rd_data), .gnt(gnt), .busy(busy));

   typedef struct {int cyc; bit m; bit we; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d;} bus_t;
   typedef struct {int cyc; bit m; logic [DATA_W-1:0] d;} ack_t;
   bus_t bq[$];
   ack_t aq[$];

   // Reference model: one transaction occupies three cycles; ties go to the
   // master not served last; a write leaves the returned read data unchanged.
   bit mlast, mgnt, w;
   logic [DATA_W-1:0] mrdq;
   int next_free;
   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         bq.delete(); aq.delete();
         mlast = 1; mgnt = 0; mrdq = '0; next_free = cyc + 1;
      end else if (cyc >= next_free && req != 2'b00) begin
         w = (req == 2'b11) ? ~mlast : req[1];
         bq.push_back('{cyc, w, we[w], addr[w], wd[w]});
         if (!we[w]) mrdq = slave_f(addr[w]);
         aq.push_back('{cyc + 1, w, mrdq});
         mgnt = w; mlast = w; next_free = cyc + 3;
      end
   end

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (cyc > 0) begin
         bit bd, ad;
         bus_t b;
         ack_t a;
         bd = bq.size() > 0 && bq[0].cyc == cyc;
         ad = aq.size() > 0 && aq[0].cyc == cyc;
         if (bd) begin
            b = bq.pop_front();
            chk("bus_cs", 64'(b_mmio_cs), 64'd1);
            chk("bus_wr", 64'(b_wr), 64'(b.we));
            chk("bus_rd", 64'(b_rd), 64'(!b.we));
            chk("bus_addr", 64'(b_addr), 64'(b.a));
            chk("bus_wdata", 64'(b_wr_data), 64'(b.d));
         end else begin
            chk("bus_idle", {b_mmio_cs, b_wr, b_rd, 29'(b_addr), b_wr_data}, 64'd0);
         end
         if (ad) begin
            a = aq.pop_front();
            chk("ack", 64'(ack), a.m ? 64'd2 : 64'd1);
            chk("m0_rd_data", 64'(m0_rd_data), a.m ? 64'd0 : 64'(a.d));
            chk("m1_rd_data", 64'(m1_rd_data), a.m ? 64'(a.d) : 64'd0);
         end else begin
            chk("ack_idle", {30'd0, ack, m0_rd_data | m1_rd_data}, 64'd0);
         end
         chk("busy", 64'(busy), 64'(bd | ad));
         chk("gnt", 64'(gnt), 64'(mgnt));
      end
   end

   // Master driver: raise req, wait for ack (bounded), optionally keep req high
   // for a back-to-back transaction or drop it early while the bus is active.
   task automatic master_txns(input int id, input int n, input bit hold, input bit drop,
                              input bit rnd, input bit we_i, input logic [ADDR_W-1:0] a_i,
                              input logic [DATA_W-1:0] d_i);
      bit keep, dr, got;
      keep = 0;
      for (int t = 0; t < n; t++) begin
         dr = rnd ? ($urandom_range(0, 3) == 0) : drop;
         if (!keep) begin
            if (rnd) repeat ($urandom_range(0, 4)) @(posedge clk);
            @(posedge clk); #1;
            req[id] = 1'b1;
         end
         we[id]   = rnd ? 1'($urandom_range(0, 1)) : we_i;
         addr[id] = rnd ? ADDR_W'($urandom) : a_i;
         wd[id]   = rnd ? DATA_W'($urandom) : d_i;
         got = 0;
         for (int c = 0; c < 15 && !got; c++) begin
            @(negedge clk);
            if (dr && b_mmio_cs && gnt == id[0]) req[id] = 1'b0;
            if (ack[id]) got = 1;
         end
         if (!got) begin
            nvec++; nfail++;
            $display("FAIL ack_timeout master=%0d got=no_ack expected=ack", id);
         end
         keep = (t < n - 1) && req[id] && (rnd ? ($urandom_range(0, 1) == 1) : hold);
         if (!keep) req[id] = 1'b0;
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      reset = 1; req = 0; we = 0;
      addr[0] = '0; addr[1] = '0; wd[0] = '0; wd[1] = '0;
      repeat (3) @(posedge clk);
      #1 reset = 0;

      master_txns(0, 1, 0, 0, 0, 1'b0, 21'h00010, 32'h0);
      repeat (2) @(posedge clk);
      master_txns(1, 1, 0, 0, 0, 1'b1, 21'h00204, 32'h0000A5A5);
      repeat (2) @(posedge clk);

      // both masters request continuously straight out of reset
      #1 reset = 1;
      @(posedge clk); #1 reset = 0;
      fork
         master_txns(0, 2, 1, 0, 0, 1'b0, 21'h00100, 32'h0);
         master_txns(1, 2, 1, 0, 0, 1'b1, 21'h00180, 32'h12345678);
      join
      repeat (2) @(posedge clk);

      master_txns(0, 3, 1, 0, 0, 1'b0, 21'h00030, 32'h0);
      repeat (2) @(posedge clk);

      // a request pulse that falls inside another transaction is ignored
      fork
         master_txns(0, 1, 0, 0, 0, 1'b1, 21'h00050, 32'hCAFEF00D);
         begin
            for (int c = 0; c < 10 && !b_mmio_cs; c++) @(negedge clk);
            req[1] = 1'b1; we[1] = 1'b1; addr[1] = 21'h00060;
            @(posedge clk); #1 req[1] = 1'b0;
         end
      join
      repeat (3) @(posedge clk);

      master_txns(1, 1, 0, 1, 0, 1'b0, 21'h00044, 32'h0);
      repeat (6) @(posedge clk);

      // reset during the BUS cycle of an m1 read
      #1 req[1] = 1'b1; we[1] = 1'b0; addr[1] = 21'h00088;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (b_mmio_cs) break;
      end
      reset = 1;
      @(posedge clk); #1 reset = 0; req[1] = 1'b0;
      repeat (2) @(posedge clk);
      fork
         master_txns(0, 1, 0, 0, 0, 1'b0, 21'h00090, 32'h0);
         master_txns(1, 1, 0, 0, 0, 1'b0, 21'h00094, 32'h0);
      join
      repeat (2) @(posedge clk);

      fork
         master_txns(0, 40, 0, 0, 1, 1'b0, '0, '0);
         master_txns(1, 40, 0, 0, 1, 1'b0, '0, '0);
      join
      repeat (5) @(posedge clk);

      if (bq.size() != 0 || aq.size() != 0) begin
         nvec++; nfail++;
         $display("FAIL leftover_expect got=%0d expected=0", bq.size() + aq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
